// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 3-sample vote, valid/ready output.
// UART_RX_OS_FIFO_EN selects a FIFO_DEPTH-entry buffer, else one holding register.
module uart_rx_os #(
  parameter int DATA_W     = 8,
  parameter int OS         = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic [DIV_W-1:0]            div,
  input  logic [3:0]                  data_bits,
  input  logic                        parity_en,
  input  logic                        parity_type,
  input  logic                        stop_bits,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_perr,
  output logic                        m_ferr,
  output logic                        m_break,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OSW = $clog2(OS);
  localparam logic [OSW-1:0] S0 = OSW'(OS / 2 - 1);
  localparam logic [OSW-1:0] S1 = OSW'(OS / 2);
  localparam logic [OSW-1:0] S2 = OSW'(OS / 2 + 1);
  localparam logic [OSW-1:0] SL = OSW'(OS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  typedef struct packed {
    logic              brk;
    logic              ferr;
    logic              perr;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_t state, state_nxt;
  logic rx_m, rx_s, rx_d, fall;
  logic [DIV_W-1:0] div_l, cnt;
  logic [OSW-1:0] os_cnt;
  logic tick, centre, v0, v1, smp;
  logic [3:0] nb, nb_l, bit_idx;
  logic last_bit, par_l, pt_l, stop2_l;
  logic [DATA_W-1:0] sh;
  logic zero_acc, perr_r, ferr_r;
  logic push, push_ok, pop, full;
  ent_t push_ent, head;

  assign fall = rx_d & ~rx_s;
  assign tick = (state != IDLE) && (cnt == div_l);
  assign centre = tick && (os_cnt == S2);
  assign smp = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign last_bit = bit_idx == nb_l - 4'd1;
  assign nb = (data_bits < 4'd5) ? 4'd5 :
              (data_bits > 4'(DATA_W)) ? 4'(DATA_W) : data_bits;

  // two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state and push decision, taken at each bit centre
  always_comb begin
    state_nxt = state;
    push = 1'b0;
    push_ent = '0;
    unique case (state)
      IDLE:   if (fall) state_nxt = START;
      START:  if (centre) state_nxt = smp ? IDLE : DATA;
      DATA:   if (centre && last_bit) state_nxt = par_l ? PARITY : STOP;
      PARITY: if (centre) state_nxt = STOP;
      STOP: begin
        if (centre) begin
          if (bit_idx == 4'd0 && zero_acc && !smp) begin
            push = 1'b1;
            push_ent.brk = 1'b1;
            push_ent.ferr = 1'b1;
            state_nxt = BRK_WAIT;
          end else if (!(bit_idx == 4'd0 && stop2_l)) begin
            push = 1'b1;
            push_ent.data = sh;
            push_ent.perr = perr_r;
            push_ent.ferr = ferr_r | ~smp;
            state_nxt = IDLE;
          end
        end
      end
      BRK_WAIT: if (rx_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // bit timing, majority voting and frame assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      os_cnt <= '0;
      div_l <= '0;
      nb_l <= 4'd5;
      par_l <= 1'b0;
      pt_l <= 1'b0;
      stop2_l <= 1'b0;
      v0 <= 1'b1;
      v1 <= 1'b1;
      sh <= '0;
      bit_idx <= '0;
      zero_acc <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
    end else if (state == IDLE) begin
      if (fall) begin
        cnt <= '0;
        os_cnt <= '0;
        div_l <= div;
        nb_l <= nb;
        par_l <= parity_en;
        pt_l <= parity_type;
        stop2_l <= stop_bits;
        sh <= '0;
        bit_idx <= '0;
        zero_acc <= 1'b1;
        perr_r <= 1'b0;
        ferr_r <= 1'b0;
      end
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        os_cnt <= (os_cnt == SL) ? '0 : os_cnt + 1'b1;
        if (os_cnt == S0) v0 <= rx_s;
        if (os_cnt == S1) v1 <= rx_s;
      end
      if (centre) begin
        unique case (state)
          DATA: begin
            sh <= sh | (DATA_W'(smp) << bit_idx);
            bit_idx <= last_bit ? 4'd0 : bit_idx + 4'd1;
            if (smp) zero_acc <= 1'b0;
          end
          PARITY: begin
            perr_r <= smp ^ (^sh) ^ pt_l;
            if (smp) zero_acc <= 1'b0;
          end
          STOP: begin
            ferr_r <= ferr_r | ~smp;
            bit_idx <= bit_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pop = m_valid & m_ready;
  assign push_ok = push & (~full | pop);

`ifdef UART_RX_OS_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  ent_t mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] cnt_f;

  assign full = cnt_f == LW'(FIFO_DEPTH);
  assign head = mem[rp];
  assign m_valid = cnt_f != '0;
  assign level = cnt_f;

  // circular buffer, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      cnt_f <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= push_ent;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt_f <= cnt_f + LW'(push_ok) - LW'(pop);
    end
  end
`else
  ent_t hold;
  logic held;

  assign full = held;
  assign head = hold;
  assign m_valid = held;
  assign level = LW'(held);

  // single holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      held <= 1'b0;
    end else begin
      if (push_ok) hold <= push_ent;
      held <= push_ok | (held & ~pop);
    end
  end
`endif

  assign m_data = m_valid ? head.data : '0;
  assign m_perr = m_valid & head.perr;
  assign m_ferr = m_valid & head.ferr;
  assign m_break = m_valid & head.brk;

  // dropped-frame pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overrun <= 1'b0;
    else      overrun <= push & ~push_ok;
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench for uart_rx_os.
// Frame-level reference model, randomized frames, queue-based checking.
module tb_uart_rx_os;
  localparam int OS = 16;
`ifdef UART_RX_OS_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic [15:0] div = 16'd13;
  logic [3:0] data_bits = 4'd8;
  logic parity_en = 1'b0;
  logic parity_type = 1'b0;
  logic stop_bits = 1'b0;
  logic m_ready = 1'b0;
  logic m_valid, m_perr, m_ferr, m_break, overrun;
  logic [7:0] m_data;
  logic [3:0] level;

  int n_chk = 0;
  int n_fail = 0;
  int ov_cnt = 0;
  int ov_exp = 0;
  bit rnd_rdy = 1'b0;
  bit force_rdy = 1'b1;
  exp_t exp_q[$];

  uart_rx_os dut (
    .clk(clk), .rst(rst), .rx(rx), .div(div),
    .data_bits(data_bits), .parity_en(parity_en),
    .parity_type(parity_type), .stop_bits(stop_bits),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_perr(m_perr), .m_ferr(m_ferr), .m_break(m_break),
    .overrun(overrun), .level(level)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_ready = rnd_rdy ? ($urandom_range(3) != 0) : force_rdy;
  end

  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (overrun) ov_cnt++;
    if (rst && m_valid && m_ready) begin
      got = {m_data, m_perr, m_ferr, m_break};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL entry_extra: got data=%h perr=%b ferr=%b brk=%b, expected none",
                 got.data, got.perr, got.ferr, got.brk);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL entry: got data=%h perr=%b ferr=%b brk=%b, expected data=%h perr=%b ferr=%b brk=%b",
                   got.data, got.perr, got.ferr, got.brk,
                   e.data, e.perr, e.ferr, e.brk);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, m_valid, m_data, m_perr, m_ferr, m_break, overrun, level};
  endfunction

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      cyc(1);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input int nb_req, input bit pen,
                      input bit pt, input bit pflip, input bit s1, input bit s2,
                      input bit two, input int dv, input bit keep);
    int nb;
    int bclk;
    logic [7:0] m;
    bit pbit;
    bit q[$];
    exp_t e;
    nb = (nb_req < 5) ? 5 : ((nb_req > 8) ? 8 : nb_req);
    m = d & 8'((9'd1 << nb) - 9'd1);
    pbit = (^m) ^ pt ^ pflip;
    bclk = OS * (dv + 1);
    div = 16'(dv);
    data_bits = 4'(nb_req);
    parity_en = pen;
    parity_type = pt;
    stop_bits = two;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) q.push_back(m[i]);
    if (pen) q.push_back(pbit);
    q.push_back(s1);
    if (two) q.push_back(s2);
    if (m == 8'd0 && (!pen || !pbit) && !s1)
      e = {8'd0, 1'b0, 1'b1, 1'b1};
    else
      e = {m, pen & pflip, !s1 || (two && !s2), 1'b0};
    if (keep) exp_q.push_back(e);
    rx = q[0];
    cyc(8);
    div = 16'($urandom);
    data_bits = 4'($urandom);
    parity_en = 1'($urandom);
    parity_type = 1'($urandom);
    stop_bits = 1'($urandom);
    cyc(bclk - 8);
    for (int i = 1; i < q.size(); i++) begin
      rx = q[i];
      cyc(bclk);
    end
    rx = 1'b1;
    cyc(bclk);
  endtask

  initial begin
    exp_t e;
    cyc(3);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    cyc(5);

    send(8'h41, 8, 1, 0, 0, 1, 1, 0, 13, 1);
    send(8'h42, 8, 1, 0, 1, 1, 1, 0, 13, 1);
    send(8'h55, 7, 1, 1, 0, 1, 0, 1, 13, 1);
    wait_drain();

    div = 16'd13;
    data_bits = 4'd7;
    parity_en = 1'b1;
    parity_type = 1'b1;
    stop_bits = 1'b1;
    e = {8'd0, 1'b0, 1'b1, 1'b1};
    exp_q.push_back(e);
    rx = 1'b0;
    cyc(12 * 224);
    rx = 1'b1;
    cyc(2 * 224);
    wait_drain();

    rx = 1'b0;
    cyc(42);
    rx = 1'b1;
    cyc(3 * 224);
    chk("false_start_level", level, 0);
    chk("false_start_valid", m_valid, 0);

    force_rdy = 1'b0;
    cyc(2);
    for (int i = 1; i <= 9; i++)
      send(8'(i), 8, 1, 0, 0, 1, 1, 0, 13, i <= CAP);
    ov_exp += 9 - CAP;
    cyc(4);
    chk("level_full", level, CAP);
    chk("overrun_pulses", ov_cnt, ov_exp);
    force_rdy = 1'b1;
    wait_drain();
    cyc(3);
    chk("level_drained", level, 0);

    force_rdy = 1'b0;
    cyc(2);
    send(8'h77, 8, 0, 0, 0, 1, 1, 0, 13, 0);
    chk("pre_reset_level", level, 1);
    div = 16'd13;
    data_bits = 4'd8;
    parity_en = 1'b0;
    stop_bits = 1'b0;
    rx = 1'b0;
    cyc(224);
    rx = 1'b1;
    cyc(224);
    rx = 1'b0;
    cyc(224);
    rx = 1'b1;
    cyc(112);
    rst = 1'b0;
    cyc(2);
    chk("reset_mid_outputs", outs(), 0);
    cyc(3);
    rst = 1'b1;
    force_rdy = 1'b1;
    cyc(224);
    send(8'h3C, 8, 0, 0, 0, 1, 1, 0, 13, 1);
    wait_drain();

    rnd_rdy = 1'b1;
    for (int k = 0; k < 14; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(4) == 0) d = 8'd0;
      send(d, $urandom_range(4, 10), 1'($urandom), 1'($urandom),
           $urandom_range(3) == 0, $urandom_range(4) != 0,
           $urandom_range(4) != 0, 1'($urandom),
           $urandom_range(2, 6), 1);
    end
    wait_drain();
    rnd_rdy = 1'b0;
    force_rdy = 1'b1;
    cyc(4);
    chk("overrun_total", ov_cnt, ov_exp);
    chk("final_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
